// File: rtl/ofs_plat_prim_rw_arb_pkg.sv
// Types and helpers shared by the read/write burst arbiter and its tests.
package ofs_plat_prim_rw_arb_pkg;

    typedef enum logic {ARB, WR_BURST} t_arb_state;
    typedef enum logic {GRANT_RD, GRANT_WR} t_grant;

    function automatic int max_payload_width(input int rd_w, input int wr_w);
        return (rd_w > wr_w) ? rd_w : wr_w;
    endfunction

endpackage

// File: rtl/ofs_plat_prim_burstcount1_fairness.sv
// Sliding-window burst-volume tracker for two channels; flags the channel that
// has fallen behind by at least FAIRNESS_THRESHOLD beats over HISTORY_DEPTH cycles.
module ofs_plat_prim_burstcount1_fairness #(
    parameter int BURST_CNT_WIDTH = 8,
    parameter int HISTORY_DEPTH = 31,
    parameter int FAIRNESS_THRESHOLD = 3 << BURST_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ch0_valid,
    input  logic [BURST_CNT_WIDTH-1:0] ch0_burstcount,
    input  logic                       ch1_valid,
    input  logic [BURST_CNT_WIDTH-1:0] ch1_burstcount,
    output logic                       favor_ch0,
    output logic                       favor_ch1
);

    localparam int SUM_W = BURST_CNT_WIDTH + $clog2(HISTORY_DEPTH + 1);
    localparam logic signed [SUM_W:0] THRESHOLD = (SUM_W + 1)'(FAIRNESS_THRESHOLD);

    logic [BURST_CNT_WIDTH-1:0] ch0_hist [HISTORY_DEPTH];
    logic [BURST_CNT_WIDTH-1:0] ch1_hist [HISTORY_DEPTH];
    logic [BURST_CNT_WIDTH-1:0] ch0_in;
    logic [BURST_CNT_WIDTH-1:0] ch1_in;
    logic [SUM_W-1:0]           ch0_sum;
    logic [SUM_W-1:0]           ch1_sum;
    logic signed [SUM_W:0]      ch0_excess;
    logic signed [SUM_W:0]      ch1_excess;

    assign ch0_in = ch0_valid ? ch0_burstcount : '0;
    assign ch1_in = ch1_valid ? ch1_burstcount : '0;

    // Running sums add the newest entry and retire the one leaving the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HISTORY_DEPTH; i++) begin
                ch0_hist[i] <= '0;
                ch1_hist[i] <= '0;
            end
            ch0_sum <= '0;
            ch1_sum <= '0;
        end else begin
            ch0_hist[0] <= ch0_in;
            ch1_hist[0] <= ch1_in;
            for (int i = 1; i < HISTORY_DEPTH; i++) begin
                ch0_hist[i] <= ch0_hist[i-1];
                ch1_hist[i] <= ch1_hist[i-1];
            end
            ch0_sum <= ch0_sum + SUM_W'(ch0_in) - SUM_W'(ch0_hist[HISTORY_DEPTH-1]);
            ch1_sum <= ch1_sum + SUM_W'(ch1_in) - SUM_W'(ch1_hist[HISTORY_DEPTH-1]);
        end
    end

    assign ch0_excess = $signed({1'b0, ch0_sum}) - $signed({1'b0, ch1_sum});
    assign ch1_excess = $signed({1'b0, ch1_sum}) - $signed({1'b0, ch0_sum});

    assign favor_ch0 = (ch1_excess >= THRESHOLD);
    assign favor_ch1 = (ch0_excess >= THRESHOLD);

endmodule

// File: rtl/ofs_plat_prim_rw_burst_arbiter.sv
// Shares one burst command port between single-beat reads and unsplittable
// write bursts: round-robin, overridden by a burst-volume fairness tracker.
module ofs_plat_prim_rw_burst_arbiter
    import ofs_plat_prim_rw_arb_pkg::*;
#(
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RD_PAYLOAD_WIDTH = 64,
    parameter int WR_PAYLOAD_WIDTH = 576,
    parameter int HISTORY_DEPTH = 31
) (
    input  logic                        clk,
    input  logic                        reset_n,

    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [BURST_CNT_WIDTH-1:0]  rd_burstcount,
    input  logic [RD_PAYLOAD_WIDTH-1:0] rd_payload,

    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [BURST_CNT_WIDTH-1:0]  wr_burstcount,
    input  logic [WR_PAYLOAD_WIDTH-1:0] wr_payload,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_is_write,
    output logic                        out_sop,
    output logic [BURST_CNT_WIDTH-1:0]  out_burstcount,
    output logic [max_payload_width(RD_PAYLOAD_WIDTH, WR_PAYLOAD_WIDTH)-1:0] out_payload
);

    localparam int OUT_PAYLOAD_WIDTH = max_payload_width(RD_PAYLOAD_WIDTH, WR_PAYLOAD_WIDTH);
    localparam int BC1_WIDTH = BURST_CNT_WIDTH + 1;

    // One extra bit so that the largest burstcount0 maps to 2^BURST_CNT_WIDTH beats.
    function automatic logic [BC1_WIDTH-1:0] to_burstcount1(input logic [BURST_CNT_WIDTH-1:0] bc0);
        return {1'b0, bc0} + BC1_WIDTH'(1);
    endfunction

    t_arb_state                 state;
    t_arb_state                 state_next;
    t_grant                     last_grant;
    t_grant                     last_grant_next;
    t_grant                     arb_grant;
    logic [BURST_CNT_WIDTH-1:0] beats_left;
    logic [BURST_CNT_WIDTH-1:0] beats_left_next;
    logic [BURST_CNT_WIDTH-1:0] burst_bc;
    logic [BURST_CNT_WIDTH-1:0] burst_bc_next;
    logic                       favor_ch0;
    logic                       favor_ch1;
    logic                       rd_accept;
    logic                       wr_first_accept;
    logic                       ch0_vld_p1;
    logic                       ch1_vld_p1;
    logic [BC1_WIDTH-1:0]       ch0_bc1_p1;
    logic [BC1_WIDTH-1:0]       ch1_bc1_p1;

    always_comb begin
        arb_grant = (last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
        if (rd_valid && !wr_valid) begin
            arb_grant = GRANT_RD;
        end else if (wr_valid && !rd_valid) begin
            arb_grant = GRANT_WR;
        end else if (favor_ch0) begin
            arb_grant = GRANT_RD;
        end else if (favor_ch1) begin
            arb_grant = GRANT_WR;
        end
    end

    always_comb begin
        state_next      = state;
        beats_left_next = beats_left;
        last_grant_next = last_grant;
        burst_bc_next   = burst_bc;
        rd_ready        = 1'b0;
        wr_ready        = 1'b0;
        out_valid       = 1'b0;
        out_is_write    = 1'b0;
        out_sop         = 1'b0;
        out_burstcount  = '0;
        out_payload     = '0;
        rd_accept       = 1'b0;
        wr_first_accept = 1'b0;

        // Outputs are forced quiet for as long as reset is held, not just at the edge.
        if (reset_n) begin
            if (state == ARB) begin
                out_sop   = 1'b1;
                out_valid = rd_valid || wr_valid;
                if (arb_grant == GRANT_WR) begin
                    out_is_write    = 1'b1;
                    out_burstcount  = wr_burstcount;
                    out_payload     = OUT_PAYLOAD_WIDTH'(wr_payload);
                    wr_ready        = wr_valid && out_ready;
                    wr_first_accept = wr_valid && out_ready;
                end else begin
                    out_burstcount  = rd_burstcount;
                    out_payload     = OUT_PAYLOAD_WIDTH'(rd_payload);
                    rd_ready        = rd_valid && out_ready;
                    rd_accept       = rd_valid && out_ready;
                end

                if (rd_accept) begin
                    last_grant_next = GRANT_RD;
                end
                if (wr_first_accept) begin
                    last_grant_next = GRANT_WR;
                    burst_bc_next   = wr_burstcount;
                    if (wr_burstcount != '0) begin
                        beats_left_next = wr_burstcount;
                        state_next      = WR_BURST;
                    end
                end
            end else begin
                out_valid      = wr_valid;
                out_is_write   = 1'b1;
                out_burstcount = burst_bc;
                out_payload    = OUT_PAYLOAD_WIDTH'(wr_payload);
                wr_ready       = wr_valid && out_ready;
                if (wr_valid && out_ready && (beats_left != '0)) begin
                    beats_left_next = beats_left - 1'b1;
                    if (beats_left == BURST_CNT_WIDTH'(1)) begin
                        state_next = ARB;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            beats_left <= '0;
            last_grant <= GRANT_WR;
            burst_bc   <= '0;
        end else begin
            state      <= state_next;
            beats_left <= beats_left_next;
            last_grant <= last_grant_next;
            burst_bc   <= burst_bc_next;
        end
    end

    // Stage p1: burstcount1 conversion of accepted requests toward the tracker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch0_vld_p1 <= 1'b0;
            ch1_vld_p1 <= 1'b0;
        end else begin
            ch0_vld_p1 <= rd_accept;
            ch1_vld_p1 <= wr_first_accept;
        end
    end

    always_ff @(posedge clk) begin
        ch0_bc1_p1 <= to_burstcount1(rd_burstcount);
        ch1_bc1_p1 <= to_burstcount1(wr_burstcount);
    end

    ofs_plat_prim_burstcount1_fairness #(
        .BURST_CNT_WIDTH(BC1_WIDTH),
        .HISTORY_DEPTH(HISTORY_DEPTH),
        .FAIRNESS_THRESHOLD(3 << BC1_WIDTH)
    ) fairness (
        .clk(clk),
        .reset_n(reset_n),
        .ch0_valid(ch0_vld_p1),
        .ch0_burstcount(ch0_bc1_p1),
        .ch1_valid(ch1_vld_p1),
        .ch1_burstcount(ch1_bc1_p1),
        .favor_ch0(favor_ch0),
        .favor_ch1(favor_ch1)
    );

endmodule

// File: tb/tb_ofs_plat_prim_rw_burst_arbiter.sv
// Randomized bench for the read/write burst arbiter against a transaction-level model
// that keeps a per-cycle log of granted burst volume and sums its sliding window.
module tb_ofs_plat_prim_rw_burst_arbiter;

    localparam int BCW    = 4;
    localparam int RDW    = 16;
    localparam int WRW    = 24;
    localparam int OUTW   = 24;
    localparam int DEPTH  = 127;
    localparam int THRESH = 3 << (BCW + 1);

    logic            clk = 1'b0;
    logic            reset_n;
    logic            rd_valid;
    logic            rd_ready;
    logic [BCW-1:0]  rd_burstcount;
    logic [RDW-1:0]  rd_payload;
    logic            wr_valid;
    logic            wr_ready;
    logic [BCW-1:0]  wr_burstcount;
    logic [WRW-1:0]  wr_payload;
    logic            out_valid;
    logic            out_ready;
    logic            out_is_write;
    logic            out_sop;
    logic [BCW-1:0]  out_burstcount;
    logic [OUTW-1:0] out_payload;

    ofs_plat_prim_rw_burst_arbiter #(
        .BURST_CNT_WIDTH(BCW),
        .RD_PAYLOAD_WIDTH(RDW),
        .WR_PAYLOAD_WIDTH(WRW),
        .HISTORY_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_burstcount(rd_burstcount),
        .rd_payload(rd_payload),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_burstcount(wr_burstcount),
        .wr_payload(wr_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_is_write(out_is_write),
        .out_sop(out_sop),
        .out_burstcount(out_burstcount),
        .out_payload(out_payload)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit m_in_burst;
    int m_left;
    int m_bc;
    bit m_last_wr;
    int q_rd[$];
    int q_wr[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_in_burst = 1'b0;
        m_left     = 0;
        m_bc       = 0;
        m_last_wr  = 1'b1;
        q_rd.delete();
        q_wr.delete();
    endtask

    // One clock cycle: drive inputs, predict outputs, compare, advance the model.
    task automatic cycle_run(input bit rst, input bit rv, input int rbc,
                             input bit wv, input int wbc, input bit ordy);
        int s_rd;
        int s_wr;
        int vol_rd;
        int vol_wr;
        bit fav_rd;
        bit fav_wr;
        bit g_wr;
        @(posedge clk);
        #1;
        reset_n       = rst;
        rd_valid      = rv;
        rd_burstcount = BCW'(rbc);
        rd_payload    = RDW'($urandom);
        wr_valid      = wv;
        wr_burstcount = BCW'(wbc);
        wr_payload    = WRW'($urandom);
        out_ready     = ordy;
        #3;
        if (!rst) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_rd_ready", rd_ready, 0);
            check_eq("rst_wr_ready", wr_ready, 0);
            model_clear();
            return;
        end

        // Window: requests accepted between DEPTH+1 and 2 cycles ago.
        s_rd = 0;
        s_wr = 0;
        for (int k = 2; k <= DEPTH + 1; k++) begin
            if (q_rd.size() >= k) begin
                s_rd += q_rd[q_rd.size() - k];
                s_wr += q_wr[q_wr.size() - k];
            end
        end
        fav_rd = ((s_wr - s_rd) >= THRESH);
        fav_wr = ((s_rd - s_wr) >= THRESH);
        vol_rd = 0;
        vol_wr = 0;

        if (m_in_burst) begin
            check_eq("burst_valid", out_valid, wv);
            check_eq("burst_rd_ready", rd_ready, 0);
            if (wv) begin
                check_eq("burst_is_write", out_is_write, 1);
                check_eq("burst_sop", out_sop, 0);
                check_eq("burst_bc", out_burstcount, m_bc);
                check_eq("burst_payload", out_payload, wr_payload);
                check_eq("burst_wr_ready", wr_ready, ordy);
                if (ordy) begin
                    m_left--;
                    if (m_left == 0) m_in_burst = 1'b0;
                end
            end
        end else begin
            if (rv && wv) g_wr = fav_rd ? 1'b0 : (fav_wr ? 1'b1 : !m_last_wr);
            else          g_wr = wv;
            check_eq("arb_valid", out_valid, rv || wv);
            if (rv || wv) begin
                check_eq("arb_is_write", out_is_write, g_wr);
                check_eq("arb_sop", out_sop, 1);
                check_eq("arb_bc", out_burstcount, g_wr ? wbc : rbc);
                check_eq("arb_payload", out_payload, g_wr ? 64'(wr_payload) : 64'(rd_payload));
            end
            if (rv) check_eq("arb_rd_ready", rd_ready, !g_wr && ordy);
            if (wv) check_eq("arb_wr_ready", wr_ready, g_wr && ordy);
            if ((rv || wv) && ordy) begin
                m_last_wr = g_wr;
                if (g_wr) begin
                    vol_wr = wbc + 1;
                    if (wbc != 0) begin
                        m_in_burst = 1'b1;
                        m_left     = wbc;
                        m_bc       = wbc;
                    end
                end else begin
                    vol_rd = rbc + 1;
                end
            end
        end

        q_rd.push_back(vol_rd);
        q_wr.push_back(vol_wr);
        if (q_rd.size() > DEPTH + 2) begin
            void'(q_rd.pop_front());
            void'(q_wr.pop_front());
        end
    endtask

    task automatic mid_reset();
        #1 reset_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_rd_ready", rd_ready, 0);
        check_eq("midrst_wr_ready", wr_ready, 0);
        model_clear();
    endtask

    initial begin
        int  read_streaks;
        bit  prev_rd;
        bit  rst;

        reset_n = 1'b0;
        rd_valid = 1'b0;
        rd_burstcount = '0;
        rd_payload = '0;
        wr_valid = 1'b0;
        wr_burstcount = '0;
        wr_payload = '0;
        out_ready = 1'b0;
        model_clear();

        repeat (3) cycle_run(0, 1, 0, 1, 0, 1);

        // Saturated single-beat traffic: strict alternation starting with read
        for (int i = 0; i < 12; i++) cycle_run(1, 1, 0, 1, 0, 1);

        // Four-beat writes competing with reads
        for (int i = 0; i < 15; i++) cycle_run(1, 1, 0, 1, 3, 1);

        // Eight-beat writes with back-pressure and bubbles; burstcount noise mid-burst
        for (int i = 0; i < 40; i++)
            cycle_run(1, 1, $urandom_range(15), ($urandom % 4) != 0,
                      m_in_burst ? $urandom_range(15) : 7, (i % 2) == 0);

        // Downstream stalled
        for (int i = 0; i < 10; i++) cycle_run(1, 1, 2, 1, 5, 0);

        // Drain any open burst, then reset during a four-beat write
        for (int i = 0; i < 20 && m_in_burst; i++) cycle_run(1, 0, 0, 1, 0, 1);
        cycle_run(1, 0, 0, 1, 3, 1);
        cycle_run(1, 0, 0, 1, 3, 1);
        mid_reset();
        cycle_run(0, 1, 0, 1, 3, 1);
        cycle_run(0, 1, 0, 1, 3, 1);
        cycle_run(1, 1, 0, 1, 3, 1);
        check_eq("post_rst_read_first", out_is_write, 0);
        check_eq("post_rst_rd_ready", rd_ready, 1);

        // Long writes vs single reads: fairness must give reads back-to-back ties
        cycle_run(0, 0, 0, 0, 0, 0);
        read_streaks = 0;
        prev_rd = 1'b0;
        for (int i = 0; i < 500; i++) begin
            cycle_run(1, 1, 0, 1, 15, 1);
            if (out_valid && out_ready && out_sop) begin
                if (!out_is_write && prev_rd) read_streaks++;
                prev_rd = !out_is_write;
            end
        end
        check_eq("fair_read_streak", read_streaks > 0, 1);

        // Unconstrained traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(199) != 0);
            cycle_run(rst, ($urandom % 3) != 0, $urandom_range(15),
                      ($urandom % 3) != 0, $urandom_range(15), ($urandom % 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
